// File: rtl/h264_coretransform_fwd.sv
// Forward 4x4 H.264 core transform: row transform into a row buffer, double-buffered
// column transform, coefficients emitted serially in zigzag order.
module h264_coretransform_fwd #(
    parameter int IW = 9,
    parameter int OW = 15
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            ENABLE,
    input  logic [4*IW-1:0] XXIN,
    output logic            READY,
    output logic            VALID,
    output logic [OW-1:0]   YNOUT,
    output logic [3:0]      ZIDX,
    output logic            LAST
);
    localparam int HW = IW + 3;

    logic [4*IW-1:0]      xreg;
    logic                 xvalid;
    logic                 hfull;
    logic                 obusy;
    logic [1:0]           rowcnt;
    logic [3:0]           ocnt;
    logic [3:0]           raster;
    logic signed [HW-1:0] xs   [4];
    logic signed [HW-1:0] hrow [4];
    logic signed [HW-1:0] hbuf [4][4];
    logic signed [HW-1:0] obuf [4][4];
    logic signed [OW-1:0] col  [4];
    logic signed [OW-1:0] ycoef;
    logic                 accept;
    logic                 hwr;
    logic                 xfer;

    assign READY  = ~hfull;
    assign accept = ENABLE & ~hfull;
    assign xfer   = hfull & (~obusy | (ocnt == 4'd15));
    // A row sampled just before H filled waits in xreg and lands in H[0] on the transfer edge.
    assign hwr    = xvalid & (~hfull | xfer);

    function automatic logic [3:0] zigzag(input logic [3:0] k);
        case (k)
            4'd0:    return 4'd0;
            4'd1:    return 4'd1;
            4'd2:    return 4'd4;
            4'd3:    return 4'd8;
            4'd4:    return 4'd5;
            4'd5:    return 4'd2;
            4'd6:    return 4'd3;
            4'd7:    return 4'd6;
            4'd8:    return 4'd9;
            4'd9:    return 4'd12;
            4'd10:   return 4'd13;
            4'd11:   return 4'd10;
            4'd12:   return 4'd7;
            4'd13:   return 4'd11;
            4'd14:   return 4'd14;
            default: return 4'd15;
        endcase
    endfunction

    always_comb begin
        for (int i = 0; i < 4; i++)
            xs[i] = {{(HW-IW){xreg[i*IW+IW-1]}}, xreg[i*IW +: IW]};
        hrow[0] = xs[0] + xs[1] + xs[2] + xs[3];
        hrow[1] = (xs[0] <<< 1) + xs[1] - xs[2] - (xs[3] <<< 1);
        hrow[2] = xs[0] - xs[1] - xs[2] + xs[3];
        hrow[3] = xs[0] - (xs[1] <<< 1) + (xs[2] <<< 1) - xs[3];
    end

    // Column transform evaluated only for the coefficient currently being emitted.
    always_comb begin
        raster = zigzag(ocnt);
        for (int i = 0; i < 4; i++)
            col[i] = {{(OW-HW){obuf[i][raster[1:0]][HW-1]}}, obuf[i][raster[1:0]]};
        ycoef = '0;
        case (raster[3:2])
            2'd0:    ycoef = col[0] + col[1] + col[2] + col[3];
            2'd1:    ycoef = (col[0] <<< 1) + col[1] - col[2] - (col[3] <<< 1);
            2'd2:    ycoef = col[0] - col[1] - col[2] + col[3];
            default: ycoef = col[0] - (col[1] <<< 1) + (col[2] <<< 1) - col[3];
        endcase
    end

    always_ff @(posedge CLK) begin
        if (accept)
            xreg <= XXIN;
        if (hwr)
            for (int j = 0; j < 4; j++)
                hbuf[rowcnt][j] <= hrow[j];
        if (xfer)
            obuf <= hbuf;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            xvalid <= 1'b0;
            rowcnt <= 2'd0;
            hfull  <= 1'b0;
            obusy  <= 1'b0;
            ocnt   <= 4'd0;
            VALID  <= 1'b0;
            LAST   <= 1'b0;
            YNOUT  <= '0;
            ZIDX   <= 4'd0;
        end else begin
            if (accept)
                xvalid <= 1'b1;
            else if (hwr)
                xvalid <= 1'b0;

            if (hwr)
                rowcnt <= rowcnt + 2'd1;

            if (hwr && rowcnt == 2'd3)
                hfull <= 1'b1;
            else if (xfer)
                hfull <= 1'b0;

            if (xfer) begin
                obusy <= 1'b1;
                ocnt  <= 4'd0;
            end else if (obusy) begin
                ocnt <= ocnt + 4'd1;
                if (ocnt == 4'd15)
                    obusy <= 1'b0;
            end

            if (obusy) begin
                VALID <= 1'b1;
                YNOUT <= ycoef;
                ZIDX  <= ocnt;
                LAST  <= (ocnt == 4'd15);
            end else begin
                VALID <= 1'b0;
                LAST  <= 1'b0;
            end
        end
    end
endmodule

// File: doc/h264_coretransform_fwd.md
Name: h264_coretransform_fwd

Overview:
- Forward 4x4 integer core transform stage, directly downstream of the intra 4x4 predictor.
- Consumes residual rows (four 9-bit differences per strobe) and the predictor's ready handshake.
- Computes Y = Cf·X·Cf^T with Cf = [1 1 1 1; 2 1 -1 -2; 1 -1 -1 1; 1 -2 2 -1].
- Emits the 16 coefficients serially in zigzag order to the quantiser, double-buffered so block throughput is one block per 16 cycles.

Parameters:
- IW, 9, residual sample width (two's complement).
- OW, 15, coefficient output width (two's complement; the worst case ±9180 fits).

Ports:
- CLK  input  1  pixel clock, rising edge.
- RST_N  input  1  reset, asynchronous, active-low.
- ENABLE  input  1  residual row valid (driven by predictor STROBEO).
- XXIN  input  36  row residuals {x3,x2,x1,x0}, 9 bits each, x0 in [8:0] = leftmost pixel.
- READY  output  1  row buffer can accept rows (drives predictor READYO).
- VALID  output  1  YNOUT valid this cycle.
- YNOUT  output  15  coefficient, sign-extended two's complement.
- ZIDX  output  4  zigzag position 0..15 of YNOUT.
- LAST  output  1  high with zigzag position 15.

Behaviour:
- Reset (RST_N=0, asynchronous): VALID=0, LAST=0, YNOUT=0, ZIDX=0, READY=1; row counter=0; hfull=0; output stage idle. Any partial block is discarded.
- Row stage:
  - ENABLE && READY on a rising edge samples XXIN.
  - The horizontal transform is computed and registered at the next edge into row buffer H[rowcnt]:
    - h0 = x0+x1+x2+x3
    - h1 = 2x0+x1-x2-2x3
    - h2 = x0-x1-x2+x3
    - h3 = x0-2x1+2x2-x3
  - h values are 12-bit signed; all arithmetic is sign-extended, no saturation.
  - rowcnt increments 0..3 and wraps to 0. When the row at rowcnt=3 is written, hfull=1.
  - ENABLE while READY=0: the row is ignored, with no state change.
- READY = ~hfull, registered-equivalent (no combinational path from ENABLE).
- Transfer:
  - When hfull=1 and the output stage is idle, or is emitting ZIDX=15 this cycle, H moves into output buffer O at the next edge and hfull clears.
  - A column transform of O (same Cf coefficients, 15-bit signed result) yields Y[v][u].
- Output stage:
  - Emits one coefficient per cycle for 16 consecutive cycles, VALID=1.
  - Raster order (index 4v+u): 0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15.
  - ZIDX counts 0..15. LAST=1 only with ZIDX=15. No output backpressure.
- Latency: with the output stage idle, ZIDX=0 appears 3 edges after the edge sampling the 4th row.
- Back-to-back: if the next block is full when ZIDX=15 is emitted, its ZIDX=0 follows on the next cycle with no gap.
- Simultaneous events:
  - If the 4th-row write and the transfer coincide, the transfer uses the completed H.
  - If a row is accepted in the transfer cycle, it writes H[0] of the next block (H is freed that edge).
- After LAST, with no pending block: VALID=0. YNOUT, ZIDX and LAST hold their last values, except LAST returns to 0.

Test Plan:
- Four rows of XXIN=0 -> VALID for 16 cycles, all YNOUT=0, ZIDX 0..15, LAST on the 16th cycle, first output 3 edges after the 4th row.
- All residuals +1 (9'h001) -> YNOUT=16 at ZIDX=0, all other 15 outputs = 0.
- Impulse x0 of row 0 = 255, all others 0 -> outputs in order: 255,510,510,255,1020,255,255,510,510,255,510,255,510,255,255,255.
- Extreme block X[y][x] = 255·sgn(c_y)·sgn(c_x), with c=[2,1,-1,-2] and values 9'h0FF/9'h101 -> YNOUT=9180 at ZIDX=4 (raster 5), no overflow anywhere.
- ENABLE held high for 12 rows (3 blocks) -> READY drops after each completed block until transfer; 48 coefficients emitted with no VALID gaps; rows presented while READY=0 are not consumed.
- RST_N pulsed low mid-output (ZIDX=7) -> VALID, LAST and YNOUT=0 immediately (asynchronously), READY=1; next four rows produce a fresh correct block.
